// File: rtl/wide_reg_access_seq_if.sv
// Wide request/response channel between the bus adapter and a partitioned-register
// access sequencer.
interface wide_reg_access_seq_if #(
  parameter int unsigned REG_WIDTH = 36
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [REG_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_wr;
  logic [REG_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata
  );
endinterface

// File: rtl/wide_reg_access_seq.sv
// Splits one wide register access into ordered single-partition beats: reads start at
// partition 0 (snapshot capture), writes end at partition 0 (commit).
module wide_reg_access_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 36,
  localparam int unsigned PARTITION_CNT = (REG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
  localparam int unsigned BusWidth      = DATA_WIDTH * PARTITION_CNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wide_reg_access_seq_if.slave     bus_io,
  output logic                     busy_o,
  output logic [PARTITION_CNT-1:0] snap_rd_en_o,
  output logic [PARTITION_CNT-1:0] snap_wr_en_o,
  output logic [BusWidth-1:0]      snap_wr_data_o,
  input  logic [BusWidth-1:0]      snap_rd_data_i
);

  localparam int unsigned IdxWidth = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(PARTITION_CNT - 1);

  typedef enum logic [1:0] {StIdle, StRdBeat, StWrBeat, StResp} state_e;

  state_e                   state_q, state_d;
  logic [IdxWidth-1:0]      idx_q, idx_d;
  logic                     wr_q, wr_d;
  logic [REG_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]     rdbuf_q, rdbuf_d;
  logic [BusWidth-1:0]      wdata_pad;
  logic [DATA_WIDTH-1:0]    beat_rd;
  logic [PARTITION_CNT-1:0] rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [BusWidth-1:0]      wr_data_q, wr_data_d;
  logic                     rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdbuf_d = rdbuf_q;
    beat_rd = snap_rd_data_i[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          wr_d    = bus_io.req_wr;
          wdata_d = bus_io.req_wdata;
          rdbuf_d = '0;
          if (bus_io.req_wr) begin
            state_d = StWrBeat;
            idx_d   = LastIdx;
          end else begin
            state_d = StRdBeat;
            idx_d   = '0;
          end
        end
      end
      StRdBeat: begin
        // Cast back to REG_WIDTH drops the unused top of the last partition.
        rdbuf_d = rdbuf_q | REG_WIDTH'(BusWidth'(beat_rd) << (int'(idx_q) * DATA_WIDTH));
        if (idx_q == LastIdx) state_d = StResp;
        else                  idx_d   = idx_q + IdxWidth'(1);
      end
      StWrBeat: begin
        if (idx_q == '0) state_d = StResp;
        else             idx_d   = idx_q - IdxWidth'(1);
      end
      StResp: begin
        if (bus_io.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Strobes are registered, so they are decoded from the next state.
    wdata_pad = BusWidth'(wdata_d);
    rd_en_d   = '0;
    wr_en_d   = '0;
    wr_data_d = '0;
    if (state_d == StRdBeat) rd_en_d = PARTITION_CNT'(1) << idx_d;
    if (state_d == StWrBeat) begin
      wr_en_d = PARTITION_CNT'(1) << idx_d;
      wr_data_d[int'(idx_d) * DATA_WIDTH +: DATA_WIDTH] =
          wdata_pad[int'(idx_d) * DATA_WIDTH +: DATA_WIDTH];
    end
    rsp_valid_d = (state_d == StResp);
    rsp_wr_d    = (state_d == StResp) & wr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdbuf_q     <= '0;
      rd_en_q     <= '0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdbuf_q     <= rdbuf_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
    end
  end

  assign bus_io.req_ready = (state_q == StIdle) & rst_n;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_wr    = rsp_wr_q;
  assign bus_io.rsp_rdata = rdbuf_q;
  assign busy_o           = (state_q != StIdle);
  assign snap_rd_en_o     = rd_en_q;
  assign snap_wr_en_o     = wr_en_q;
  assign snap_wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_wide_reg_access_seq.sv
// Drives a 36-bit (two-partition) and a 32-bit (single-partition) sequencer against
// behavioural snapshot-register targets and checks every beat and response.
module tb_wide_reg_access_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wide_reg_access_seq_if #(.REG_WIDTH(36)) bus_a ();
  wide_reg_access_seq_if #(.REG_WIDTH(32)) bus_b ();

  logic        busy_a, busy_b;
  logic [1:0]  rd_en_a, wr_en_a;
  logic [63:0] wr_data_a, rd_data_a;
  logic [0:0]  rd_en_b, wr_en_b;
  logic [31:0] wr_data_b, rd_data_b;

  wide_reg_access_seq #(.DATA_WIDTH(32), .REG_WIDTH(36)) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_io         (bus_a),
    .busy_o         (busy_a),
    .snap_rd_en_o   (rd_en_a),
    .snap_wr_en_o   (wr_en_a),
    .snap_wr_data_o (wr_data_a),
    .snap_rd_data_i (rd_data_a)
  );

  wide_reg_access_seq #(.DATA_WIDTH(32), .REG_WIDTH(32)) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_io         (bus_b),
    .busy_o         (busy_b),
    .snap_rd_en_o   (rd_en_b),
    .snap_wr_en_o   (wr_en_b),
    .snap_wr_data_o (wr_data_b),
    .snap_rd_data_i (rd_data_b)
  );

  // Snapshot register target: partition-0 read latches the upper part, partition-0
  // write commits the staged upper part together with the low word.
  logic [35:0] live_a = '0;
  logic [3:0]  snap_hi_a = '0;
  logic [3:0]  stage_hi_a = '0;
  logic        poke_en = 1'b0;
  logic [35:0] poke_val = '0;
  logic [31:0] live_b = '0;

  assign rd_data_a = {28'h0, snap_hi_a, live_a[31:0]};
  assign rd_data_b = live_b;

  always @(posedge clk) begin
    if (wr_en_a[1]) stage_hi_a <= wr_data_a[35:32];
    if (wr_en_a[0]) live_a <= {stage_hi_a, wr_data_a[31:0]};
    if (rd_en_a[0]) snap_hi_a <= live_a[35:32];
    if (poke_en) live_a <= poke_val;
    if (wr_en_b[0]) live_b <= wr_data_b;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [35:0] ref_a = '0;
  logic [31:0] ref_b = '0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp_a(input logic wr, input logic [35:0] exp_rd);
    check_eq("a_rsp_valid", bus_a.rsp_valid, 1);
    check_eq("a_rsp_wr", bus_a.rsp_wr, wr);
    check_eq("a_rsp_rdata", bus_a.rsp_rdata, exp_rd);
    check_eq("a_rsp_strobes", {rd_en_a, wr_en_a}, 0);
    check_eq("a_rsp_ready_low", bus_a.req_ready, 0);
    check_eq("a_rsp_busy", busy_a, 1);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic access_a(input logic wr, input logic [35:0] data, input int stall,
                          input logic hold, input logic poke);
    logic [35:0] exp_rd;
    exp_rd = wr ? 36'h0 : ref_a;
    bus_a.req_valid = 1'b1;
    bus_a.req_wr    = wr;
    bus_a.req_wdata = data;
    check_eq("a_req_ready", bus_a.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus_a.req_wr    = ~wr;
      bus_a.req_wdata = {4'hF, 32'($urandom)};
    end else begin
      bus_a.req_valid = 1'b0;
    end
    check_eq("a_beat1_rd_en", rd_en_a, wr ? 2'b00 : 2'b01);
    check_eq("a_beat1_wr_en", wr_en_a, wr ? 2'b10 : 2'b00);
    check_eq("a_beat1_wdata", wr_data_a, wr ? {28'h0, data[35:32], 32'h0} : 64'h0);
    check_eq("a_beat1_busy", busy_a, 1);
    check_eq("a_beat1_rsp", bus_a.rsp_valid, 0);
    @(negedge clk);
    check_eq("a_beat2_rd_en", rd_en_a, wr ? 2'b00 : 2'b10);
    check_eq("a_beat2_wr_en", wr_en_a, wr ? 2'b01 : 2'b00);
    check_eq("a_beat2_wdata", wr_data_a, wr ? {32'h0, data[31:0]} : 64'h0);
    check_eq("a_beat2_rsp", bus_a.rsp_valid, 0);
    if (poke) begin
      poke_val = 36'h5_0000_0000;
      poke_en  = 1'b1;
    end
    @(negedge clk);
    poke_en = 1'b0;
    check_rsp_a(wr, exp_rd);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_rsp_a(wr, exp_rd);
    end
    bus_a.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check_eq("a_idle_rsp_valid", bus_a.rsp_valid, 0);
    check_eq("a_idle_busy", busy_a, 0);
    check_eq("a_idle_ready", bus_a.req_ready, 1);
    if (wr) ref_a = data;
    if (poke) ref_a = poke_val;
  endtask

  task automatic access_b(input logic wr, input logic [31:0] data);
    logic [31:0] exp_rd;
    exp_rd = wr ? 32'h0 : ref_b;
    bus_b.req_valid = 1'b1;
    bus_b.req_wr    = wr;
    bus_b.req_wdata = data;
    check_eq("b_req_ready", bus_b.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    check_eq("b_beat_rd_en", rd_en_b, wr ? 1'b0 : 1'b1);
    check_eq("b_beat_wr_en", wr_en_b, wr ? 1'b1 : 1'b0);
    check_eq("b_beat_wdata", wr_data_b, wr ? data : 32'h0);
    @(negedge clk);
    check_eq("b_rsp_valid", bus_b.rsp_valid, 1);
    check_eq("b_rsp_wr", bus_b.rsp_wr, wr);
    check_eq("b_rsp_rdata", bus_b.rsp_rdata, exp_rd);
    check_eq("b_rsp_strobes", {rd_en_b, wr_en_b}, 0);
    bus_b.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.rsp_ready = 1'b0;
    check_eq("b_idle_rsp_valid", bus_b.rsp_valid, 0);
    if (wr) ref_b = data;
  endtask

  task automatic check_all_zero_a(input string tag);
    check_eq({tag, "_ready"}, bus_a.req_ready, 0);
    check_eq({tag, "_outs"}, {bus_a.rsp_valid, bus_a.rsp_wr, busy_a, rd_en_a, wr_en_a}, 0);
    check_eq({tag, "_wdata"}, wr_data_a, 0);
    check_eq({tag, "_rdata"}, bus_a.rsp_rdata, 0);
  endtask

  initial begin
    logic [35:0] d;
    bus_a.req_valid = 1'b0; bus_a.req_wr = 1'b0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_wr = 1'b0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero_a("rst");
    check_eq("rst_b_ready", bus_b.req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", bus_a.req_ready, 1);
    check_eq("post_rst_busy", busy_a, 0);

    access_a(1'b1, 36'h9_1234_5678, 0, 1'b0, 1'b0);
    access_a(1'b0, 36'h0, 0, 1'b0, 1'b0);
    check_eq("target_after_write", live_a, 36'h9_1234_5678);

    // Coherency: upper half changes between the two read beats.
    access_a(1'b1, 36'hA_DEAD_BEEF, 1, 1'b0, 1'b0);
    access_a(1'b0, 36'h0, 0, 1'b0, 1'b1);

    // Backpressure with a request held pending; it is accepted right after.
    access_a(1'b0, 36'h0, 5, 1'b1, 1'b0);
    access_a(1'b0, 36'h0, 0, 1'b0, 1'b0);

    // Reset one cycle after the first write beat.
    access_a(1'b1, 36'h0, 0, 1'b0, 1'b0);
    bus_a.req_valid = 1'b1;
    bus_a.req_wr    = 1'b1;
    bus_a.req_wdata = 36'h9_1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check_eq("rstmid_beat1", wr_en_a, 2'b10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero_a("rstmid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rstmid_no_rsp", {bus_a.rsp_valid, wr_en_a, rd_en_a}, 0);
    end
    check_eq("rstmid_target", live_a, 36'h0);
    ref_a = 36'h0;
    access_a(1'b0, 36'h0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      d[31:0]  = $urandom;
      d[35:32] = 4'($urandom_range(15, 0));
      access_a(1'($urandom_range(1, 0)), d, int'($urandom_range(3, 0)), 1'b0, 1'b0);
    end

    access_b(1'b1, 32'hCAFE_F00D);
    access_b(1'b0, 32'h0);
    for (int n = 0; n < 6; n++) access_b(1'($urandom_range(1, 0)), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_reg_access_seq.md
# wide_reg_access_seq

Bus-side initiator for partitioned snapshot registers: accepts one wide (REG_WIDTH) read or write request and converts it into a sequence of single-partition, DATA_WIDTH-wide accesses on the snapshot-register interface, in the order that register requires for atomicity. For reads, partition 0 goes first, which captures the snapshot; for writes, upper partitions are staged first and partition 0 last, which commits. Sits between the CPU/bus adapter and each snapshot register instance.

## Interface
- DATA_WIDTH, 32: width of one bus beat/partition.
- REG_WIDTH, 36: width of target register.
- PARTITION_CNT, ceil(REG_WIDTH/DATA_WIDTH): derived, not overridden.
- REM_WIDTH, REG_WIDTH % DATA_WIDTH: localparam; 0 means last partition full.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  wide request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_wr  in  1  1 = write, 0 = read.
- req_wdata  in  REG_WIDTH  write data.
- rsp_valid  out  1  access complete.
- rsp_ready  in  1  response consumed.
- rsp_wr  out  1  echo of req_wr for this response.
- rsp_rdata  out  REG_WIDTH  assembled read data (0 for writes).
- busy  out  1  high from acceptance through response handshake.
- snap_rd_en  out  PARTITION_CNT  one-hot read strobe.
- snap_wr_en  out  PARTITION_CNT  one-hot write strobe.
- snap_wr_data  out  DATA_WIDTH*PARTITION_CNT  active slice carries beat data; all other slices 0.
- snap_rd_data  in  DATA_WIDTH*PARTITION_CNT  per-partition read data, valid combinationally in the strobe cycle.

## Operation
- States: IDLE, RD_BEAT, WR_BEAT, RESP. Beat counter idx, width max(1, clog2(PARTITION_CNT)).
- IDLE: req_ready=1. On req_valid&req_ready, latch req_wr and req_wdata, and clear the read buffer.
  - Read: go to RD_BEAT with idx=0.
  - Write: go to WR_BEAT with idx=PARTITION_CNT-1.
- RD_BEAT: assert snap_rd_en[idx] for one cycle. Capture snap_rd_data[idx*DW +: DW] into buffer slice idx; the last slice is truncated to REM_WIDTH when REM_WIDTH≠0. idx increments. After idx=PARTITION_CNT-1, go to RESP.
- WR_BEAT: assert snap_wr_en[idx] for one cycle and drive snap_wr_data[idx*DW +: DW] = latched data slice.
  - Last partition: data zero-padded above REM_WIDTH.
  - idx decrements. After idx=0, go to RESP.
- Partition 0 is always the read's first beat and the write's last beat. Never reorder.
- RESP: rsp_valid=1, with rsp_wr and rsp_rdata held stable until rsp_ready. On handshake, return to IDLE.
- Read and write strobes are never asserted in the same cycle. At most one strobe bit is high per cycle.
- PARTITION_CNT=1: one beat on partition 0 only.
- req_valid outside IDLE is ignored; no queuing.

## Timing
- Reset values: req_ready=0 while rst_n low, then 1 (IDLE). rsp_valid=0, rsp_wr=0, rsp_rdata=0, busy=0, all strobes 0, snap_wr_data=0.
- Acceptance at cycle T. Beats occupy T+1 .. T+PARTITION_CNT. rsp_valid first high at T+PARTITION_CNT+1.
- Strobes, snap_wr_data and rsp_* are registered outputs.
- Read data is sampled at the clock edge ending each strobe cycle.
- Earliest next acceptance is the cycle after the rsp handshake.
- Reset mid-sequence forces IDLE asynchronously and clears all outputs and buffers. Remaining beats are not issued, and no response is produced.

## Test plan
- DW=32, RW=36, write 36'h9_1234_5678.
  - Beat 1: snap_wr_en=2'b10, slice1=32'h0000_0009, slice0=0.
  - Beat 2: snap_wr_en=2'b01, slice0=32'h1234_5678.
  - Then rsp_valid=1, rsp_wr=1, rsp_rdata=0. Target model reads back 36'h9_1234_5678.
- DW=32, RW=36, read, target holds 36'hA_DEAD_BEEF.
  - snap_rd_en=2'b01, then 2'b10.
  - rsp_rdata=36'hA_DEAD_BEEF, rsp_valid at T+3.
- Snapshot coherency: target register changes to 36'h5_0000_0000 between the two read beats. Response is still 36'hA_DEAD_BEEF, because the upper half comes from the snapshot.
- Backpressure: rsp_ready held 0 for 5 cycles with req_valid held 1.
  - rsp_valid and rsp_rdata stay stable; req_ready=0; no strobes.
  - Acceptance happens the cycle after rsp_ready=1.
- Reset asserted one cycle after the first write beat (36'h9_1234_5678 onto a register holding 0).
  - All outputs go 0 immediately; the partition-0 beat is never issued.
  - Target register stays 0; no rsp_valid after release.
- RW=32, DW=32, write 32'hCAFE_F00D then read.
  - Single-beat strobes 1'b1 each; latency 1 beat.
  - Read returns 32'hCAFE_F00D.
